// File: rtl/force_reg_bank.sv
// Multi-channel clocked sample registers with per-channel indefinite or timed force/release.
// Define FORCE_REG_BANK_STATS_EN to build the saturating accepted-force counter.

module force_reg_lane #(
   parameter int WIDTH   = 8,
   parameter int TIMER_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   d,
   input  logic               frc,
   input  logic               rel,
   input  logic [WIDTH-1:0]   frc_val,
   input  logic [TIMER_W-1:0] frc_cyc,
   output logic [WIDTH-1:0]   q,
   output logic               forced
);
   typedef enum logic [1:0] {NORMAL, HOLD, TIMED} state_t;

   state_t             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic               forced_q, forced_d;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      q_d     = q_q;
      // A force always wins, including over a release to the same lane.
      if (frc) begin
         q_d = frc_val;
         if (frc_cyc == '0) begin
            state_d = HOLD;
            timer_d = '0;
         end else begin
            state_d = TIMED;
            timer_d = frc_cyc - TIMER_W'(1);
         end
      end else begin
         case (state_q)
            HOLD: begin
               if (rel) begin
                  state_d = NORMAL;
                  q_d     = d;
               end
            end
            TIMED: begin
               if (rel || timer_q == '0) begin
                  state_d = NORMAL;
                  timer_d = '0;
                  q_d     = d;
               end else begin
                  timer_d = timer_q - TIMER_W'(1);
               end
            end
            default: begin
               state_d = NORMAL;
               q_d     = d;
            end
         endcase
      end
      forced_d = (state_d != NORMAL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= NORMAL;
         timer_q  <= '0;
         q_q      <= '0;
         forced_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         q_q      <= q_d;
         forced_q <= forced_d;
      end
   end

   assign q      = q_q;
   assign forced = forced_q;
endmodule

module force_reg_bank #(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   parameter  int TIMER_W  = 8,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [CHANNELS*WIDTH-1:0]    d_in,
   input  logic                         force_req,
   input  logic [CH_W-1:0]              force_ch,
   input  logic [WIDTH-1:0]             force_val,
   input  logic [TIMER_W-1:0]           force_cycles,
   input  logic                         release_req,
   input  logic [CH_W-1:0]              release_ch,
   output logic [CHANNELS*WIDTH-1:0]    q_out,
   output logic [CHANNELS-1:0]          forced,
   output logic                         cmd_err,
   output logic [15:0]                  force_count
);
   localparam int unsigned NCH = CHANNELS;

   logic force_bad, release_bad;
   logic cmd_err_q, cmd_err_d;

   // Widen before comparing so a power-of-two CHANNELS does not wrap in CH_W bits.
   assign force_bad   = force_req   && (32'(force_ch)   >= NCH);
   assign release_bad = release_req && (32'(release_ch) >= NCH);

   always_comb begin
      cmd_err_d = force_bad || release_bad;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cmd_err_q <= 1'b0;
      else     cmd_err_q <= cmd_err_d;
   end

   assign cmd_err = cmd_err_q;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      force_reg_lane #(
         .WIDTH   (WIDTH),
         .TIMER_W (TIMER_W)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .d       (d_in[c*WIDTH +: WIDTH]),
         .frc     (force_req && (force_ch == CH_W'(c))),
         .rel     (release_req && (release_ch == CH_W'(c))),
         .frc_val (force_val),
         .frc_cyc (force_cycles),
         .q       (q_out[c*WIDTH +: WIDTH]),
         .forced  (forced[c])
      );
   end

`ifdef FORCE_REG_BANK_STATS_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (force_req && !force_bad && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign force_count = cnt_q;
`else
   assign force_count = '0;
`endif
endmodule

// File: tb/tb_force_reg_bank.sv
// Randomised and directed bench for force_reg_bank against a cycles-remaining reference model.
// Built with five channels so both valid high indices and out-of-range indices exist.

module tb_force_reg_bank;
   localparam int W  = 8;
   localparam int CH = 5;
   localparam int TW = 8;
   localparam int CW = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [CH*W-1:0]   d_in;
   logic              force_req;
   logic [CW-1:0]     force_ch;
   logic [W-1:0]      force_val;
   logic [TW-1:0]     force_cycles;
   logic              release_req;
   logic [CW-1:0]     release_ch;
   logic [CH*W-1:0]   q_out;
   logic [CH-1:0]     forced;
   logic              cmd_err;
   logic [15:0]       force_count;

   force_reg_bank #(.WIDTH(W), .CHANNELS(CH), .TIMER_W(TW)) dut (
      .clk          (clk),
      .rst          (rst),
      .d_in         (d_in),
      .force_req    (force_req),
      .force_ch     (force_ch),
      .force_val    (force_val),
      .force_cycles (force_cycles),
      .release_req  (release_req),
      .release_ch   (release_ch),
      .q_out        (q_out),
      .forced       (forced),
      .cmd_err      (cmd_err),
      .force_count  (force_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: left[c] = cycles the forced value is still to be shown (-1 indefinite, 0 not forced).
   int              left [CH];
   logic [W-1:0]    fval [CH];
   logic [CH*W-1:0] exp_q;
   logic [CH-1:0]   exp_forced;
   logic            exp_err;
   logic [15:0]     exp_cnt;

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         left[c] = 0;
         fval[c] = '0;
      end
      exp_q = '0; exp_forced = '0; exp_err = 1'b0; exp_cnt = '0;
   endtask

   task automatic model_step();
      logic [W-1:0] dc;
      exp_err = (force_req && int'(force_ch) >= CH) || (release_req && int'(release_ch) >= CH);
`ifdef FORCE_REG_BANK_STATS_EN
      if (force_req && int'(force_ch) < CH && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
      for (int c = 0; c < CH; c++) begin
         dc = d_in[c*W +: W];
         if (force_req && int'(force_ch) == c) begin
            fval[c] = force_val;
            left[c] = (force_cycles == 0) ? -1 : int'(force_cycles);
            exp_q[c*W +: W] = force_val;
         end else if (left[c] == 0 || (release_req && int'(release_ch) == c)) begin
            left[c] = 0;
            exp_q[c*W +: W] = dc;
         end else if (left[c] > 0) begin
            left[c] = left[c] - 1;
            exp_q[c*W +: W] = (left[c] == 0) ? dc : fval[c];
         end else begin
            exp_q[c*W +: W] = fval[c];
         end
         exp_forced[c] = (left[c] != 0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_step();
      #1;
   endtask

   task automatic idle();
      force_req = 1'b0; release_req = 1'b0;
   endtask

   task automatic cmd_force(input int ch, input logic [W-1:0] v, input int cyc);
      force_req = 1'b1; force_ch = CW'(ch); force_val = v; force_cycles = TW'(cyc);
   endtask

   task automatic test_reset();
      rst = 1'b1; d_in = '0; idle(); force_ch = '0; release_ch = '0;
      force_val = '0; force_cycles = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (q_out !== '0) begin errors++; $display("FAIL reset_q: got %h exp 0", q_out); end
      checks++; if (forced !== '0) begin errors++; $display("FAIL reset_forced: got %b exp 0", forced); end
      checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", cmd_err); end
      checks++; if (force_count !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", force_count); end
      rst = 1'b0;
   endtask

   task automatic test_sample();
      d_in = '0; d_in[0*W +: W] = 8'h5A;
      tick();
      checks++; if (q_out[0*W +: W] !== 8'h5A) begin errors++; $display("FAIL sample_ch0: got %h exp 5a", q_out[0*W +: W]); end
      checks++; if (forced !== '0) begin errors++; $display("FAIL sample_forced: got %b exp 0", forced); end
      checks++; if (force_count !== 16'd0) begin errors++; $display("FAIL sample_cnt: got %0d exp 0", force_count); end
      checks++; if (q_out !== exp_q) begin errors++; $display("FAIL sample_q: got %h exp %h", q_out, exp_q); end
   endtask

   task automatic test_hold();
      cmd_force(1, 8'hC3, 0);
      tick(); idle();
      for (int i = 0; i < 10; i++) begin
         d_in[1*W +: W] = (i % 2 == 1) ? 8'hFF : 8'h00;
         tick();
         checks++; if (q_out[1*W +: W] !== 8'hC3 || forced[1] !== 1'b1) begin
            errors++; $display("FAIL hold_ch1: got %h/%b exp c3/1", q_out[1*W +: W], forced[1]);
         end
      end
      d_in[1*W +: W] = 8'h3E;
      release_req = 1'b1; release_ch = 3'd1;
      tick(); idle();
      checks++; if (q_out[1*W +: W] !== 8'h3E || forced[1] !== 1'b0) begin
         errors++; $display("FAIL hold_release: got %h/%b exp 3e/0", q_out[1*W +: W], forced[1]);
      end
      d_in[1*W +: W] = 8'h81;
      tick();
      checks++; if (q_out !== exp_q || forced !== exp_forced) begin
         errors++; $display("FAIL hold_follow: got %h/%b exp %h/%b", q_out, forced, exp_q, exp_forced);
      end
   endtask

   task automatic test_timed();
      d_in[2*W +: W] = 8'h77;
      cmd_force(2, 8'h11, 3);
      tick(); idle();
      for (int i = 0; i < 5; i++) begin
         checks++; if (q_out[2*W +: W] !== ((i < 3) ? 8'h11 : 8'h77) || forced[2] !== (i < 3)) begin
            errors++; $display("FAIL timed_ch2[%0d]: got %h/%b", i, q_out[2*W +: W], forced[2]);
         end
         tick();
      end
   endtask

   task automatic test_same_cycle();
      cmd_force(0, 8'h3C, 0);
      tick(); idle();
      cmd_force(3, 8'hAA, 0);
      release_req = 1'b1; release_ch = 3'd3;
      tick(); idle();
      checks++; if (q_out[3*W +: W] !== 8'hAA || forced[3] !== 1'b1) begin
         errors++; $display("FAIL same_ch3: got %h/%b exp aa/1", q_out[3*W +: W], forced[3]);
      end
      checks++; if (q_out[0*W +: W] !== 8'h3C || forced[0] !== 1'b1) begin
         errors++; $display("FAIL same_ch0: got %h/%b exp 3c/1", q_out[0*W +: W], forced[0]);
      end
      d_in[2*W +: W] = 8'h44;
      cmd_force(2, 8'h22, 3);
      tick(); idle();
      tick();
      cmd_force(2, 8'h33, 5);
      tick(); idle();
      for (int i = 0; i < 7; i++) begin
         checks++; if (q_out[2*W +: W] !== ((i < 5) ? 8'h33 : 8'h44) || forced[2] !== (i < 5)) begin
            errors++; $display("FAIL reforce_ch2[%0d]: got %h/%b", i, q_out[2*W +: W], forced[2]);
         end
         tick();
      end
      release_req = 1'b1; release_ch = 3'd0;
      tick();
      release_ch = 3'd3;
      tick();
      release_ch = 3'd4;
      tick(); idle();
      checks++; if (forced !== '0 || q_out !== exp_q || cmd_err !== 1'b0) begin
         errors++; $display("FAIL release_all: got %h/%b/%b exp %h/0/0", q_out, forced, cmd_err, exp_q);
      end
   endtask

   task automatic test_bad_cmd();
      logic [CH*W-1:0] q_before;
      logic [CH-1:0]   f_before;
      logic [15:0]     c_before;
      cmd_force(1, 8'h9D, 0);
      tick(); idle();
      q_before = exp_q; f_before = exp_forced; c_before = exp_cnt;
      d_in[1*W +: W] = 8'h12;
      cmd_force(5, 8'hEE, 0);
      tick(); idle();
      checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL bad_err: got %b exp 1", cmd_err); end
      checks++; if (forced !== f_before || q_out[1*W +: W] !== q_before[1*W +: W]) begin
         errors++; $display("FAIL bad_state: got %h/%b exp %h/%b", q_out, forced, q_before, f_before);
      end
      checks++; if (force_count !== exp_cnt || exp_cnt !== c_before) begin
         errors++; $display("FAIL bad_cnt: got %0d exp %0d", force_count, c_before);
      end
      tick();
      checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL bad_pulse: got %b exp 0", cmd_err); end
      cmd_force(7, 8'h01, 2);
      release_req = 1'b1; release_ch = 3'd6;
      tick(); idle();
      checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL both_bad_err: got %b exp 1", cmd_err); end
      tick();
      checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL both_bad_pulse: got %b exp 0", cmd_err); end
      checks++; if (q_out !== exp_q || forced !== exp_forced || force_count !== exp_cnt) begin
         errors++; $display("FAIL bad_model: got %h/%b/%0d exp %h/%b/%0d", q_out, forced, force_count, exp_q, exp_forced, exp_cnt);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         d_in         = (CH*W)'({$urandom(), $urandom()});
         force_req    = ($urandom_range(0, 3) == 0);
         force_ch     = CW'($urandom_range(0, 7));
         force_val    = W'($urandom());
         force_cycles = ($urandom_range(0, 3) == 0) ? TW'(0) : TW'($urandom_range(1, 6));
         release_req  = ($urandom_range(0, 4) == 0);
         release_ch   = CW'($urandom_range(0, 7));
         tick();
         checks++; if (q_out !== exp_q) begin errors++; $display("FAIL rand_q[%0d]: got %h exp %h", i, q_out, exp_q); end
         checks++; if (forced !== exp_forced) begin errors++; $display("FAIL rand_forced[%0d]: got %b exp %b", i, forced, exp_forced); end
         checks++; if (cmd_err !== exp_err) begin errors++; $display("FAIL rand_err[%0d]: got %b exp %b", i, cmd_err, exp_err); end
         checks++; if (force_count !== exp_cnt) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d exp %0d", i, force_count, exp_cnt); end
      end
      idle();
   endtask

   task automatic test_async_reset();
      d_in[2*W +: W] = 8'h55;
      cmd_force(2, 8'hB4, 10);
      tick(); idle();
      tick();
      checks++; if (q_out[2*W +: W] !== 8'hB4 || forced[2] !== 1'b1) begin
         errors++; $display("FAIL pre_rst_ch2: got %h/%b exp b4/1", q_out[2*W +: W], forced[2]);
      end
      #2;
      rst = 1'b1; model_reset();
      #1;
      checks++; if (q_out !== '0 || forced !== '0) begin
         errors++; $display("FAIL async_rst: got %h/%b exp 0/0", q_out, forced);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      d_in[2*W +: W] = 8'h66;
      tick();
      checks++; if (q_out[2*W +: W] !== 8'h66 || forced[2] !== 1'b0) begin
         errors++; $display("FAIL post_rst_ch2: got %h/%b exp 66/0", q_out[2*W +: W], forced[2]);
      end
      checks++; if (q_out !== exp_q || force_count !== exp_cnt) begin
         errors++; $display("FAIL post_rst_model: got %h/%0d exp %h/%0d", q_out, force_count, exp_q, exp_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_sample();
      test_hold();
      test_timed();
      test_same_cycle();
      test_bad_cmd();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
